// File: rtl/cfg_sched_pkg.sv
// cfg_sched_pkg: shared FSM encoding, register-count default and minimum line length.
package cfg_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_LAUNCH, ST_HOLDOFF} state_e;
  localparam int CFG_REGS_DEF = 2;
  localparam logic [15:0] MIN_LP = 16'd2;
endpackage

// File: rtl/cfg_line_timer.sv
// cfg_line_timer: free-running line counter with a registered one-cycle LINE_SYNC at count zero.
module cfg_line_timer
  import cfg_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] line_period,
  output logic        line_sync
);
  logic [15:0] cnt_q, cnt_d, lp;
  logic        sync_q, sync_d;
  always_comb begin
    lp = (line_period < MIN_LP) ? MIN_LP : line_period;
    cnt_d = (cnt_q >= lp - 16'd1) ? '0 : cnt_q + 16'd1;
    sync_d = (cnt_q == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sync_q <= sync_d;
    end
  end
  assign line_sync = sync_q;
endmodule

// File: rtl/cfg_update_sched.sv
// cfg_update_sched: tracks dirty config registers and launches one transmitter update per line,
// with completion on a fresh TX_END rise, a launch timeout and a sticky error flag.
module cfg_update_sched
  import cfg_sched_pkg::*;
#(
  parameter int CFG_REGS    = CFG_REGS_DEF,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic [15:0]         LINE_PERIOD,
  input  logic                ENABLE,
  input  logic                FORCE,
  input  logic                WE_A,
  input  logic [2:0]          ADD_A,
  input  logic                TX_END,
  input  logic                ERR_CLR,
  output logic                START,
  output logic                LINE_SYNC,
  output logic                BUSY,
  output logic [CFG_REGS-1:0] DIRTY,
  output logic                ERR_TIMEOUT,
  output logic [15:0]         UPD_CNT
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e              state_q, state_d;
  logic [CFG_REGS-1:0] dirty_q, dirty_d, inflight_q, inflight_d, wr_mask, set_mask;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [15:0]         upd_q, upd_d;
  logic                start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic                seen_q, seen_d, tx_prev_q;
  logic                line_sync, tx_rise, launch, done, tmo;

  cfg_line_timer u_timer (
    .clk        (CLOCK),
    .rst_n      (RESET_N),
    .line_period(LINE_PERIOD),
    .line_sync  (line_sync)
  );

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < CFG_REGS; i++) wr_mask[i] = WE_A && (ADD_A[2:1] == 2'(i));
    set_mask = FORCE ? '1 : wr_mask;
    tx_rise = TX_END && !tx_prev_q;
    launch = (state_q == ST_ARMED) && ENABLE && line_sync;
    done = (state_q == ST_LAUNCH) && tx_rise;
    tmo = (state_q == ST_LAUNCH) && !tx_rise && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = (|dirty_q && ENABLE) ? ST_ARMED : ST_IDLE;
      ST_ARMED:   state_d = !ENABLE ? ST_IDLE : line_sync ? ST_LAUNCH : ST_ARMED;
      ST_LAUNCH:  state_d = done ? ST_HOLDOFF : tmo ? ST_IDLE : ST_LAUNCH;
      ST_HOLDOFF: state_d = ((seen_q || line_sync) && !TX_END) ? ST_IDLE : ST_HOLDOFF;
      default:    state_d = ST_IDLE;
    endcase
    tmo_cnt_d = (state_q == ST_LAUNCH) ? tmo_cnt_q + TW'(1) : '0;
    seen_d = (state_q == ST_HOLDOFF) && (seen_q || line_sync);
    // New writes are ORed in last so they survive both the launch clear and a timeout restore.
    dirty_d = (launch ? '0 : dirty_q) | (tmo ? inflight_q : '0) | set_mask;
    inflight_d = launch ? dirty_q : inflight_q;
    start_d = (state_d == ST_LAUNCH);
    busy_d = (state_d == ST_LAUNCH) || (state_d == ST_HOLDOFF);
    err_d = tmo || (err_q && !ERR_CLR);
    upd_d = upd_q + 16'(done);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      dirty_q <= '0;
      inflight_q <= '0;
      tmo_cnt_q <= '0;
      upd_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      seen_q <= 1'b0;
      tx_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      inflight_q <= inflight_d;
      tmo_cnt_q <= tmo_cnt_d;
      upd_q <= upd_d;
      start_q <= start_d;
      busy_q <= busy_d;
      err_q <= err_d;
      seen_q <= seen_d;
      tx_prev_q <= TX_END;
    end
  end

  assign START = start_q;
  assign LINE_SYNC = line_sync;
  assign BUSY = busy_q;
  assign DIRTY = dirty_q;
  assign ERR_TIMEOUT = err_q;
  assign UPD_CNT = upd_q;
endmodule

// File: tb/tb_cfg_update_sched.sv
// tb_cfg_update_sched: directed vector table for dirty tracking plus hand sequences for launch,
// completion, timeout, reset and line-timer corner cases.
module tb_cfg_update_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] line_period = 16'd100;
  logic        enable = 1'b0, force_upd = 1'b0, we_a = 1'b0, tx_end = 1'b0, err_clr = 1'b0;
  logic [2:0]  add_a = 3'b000;
  logic        start, line_sync, busy, err_timeout;
  logic [1:0]  dirty;
  logic [15:0] upd_cnt;
  int          errors = 0, checks = 0;

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] add;
    logic       frc;
    logic [1:0] exp_dirty;
  } vec_t;
  vec_t vecs[9];

  cfg_update_sched #(.CFG_REGS(2), .TIMEOUT_CYC(64)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .LINE_PERIOD(line_period), .ENABLE(enable),
    .FORCE(force_upd), .WE_A(we_a), .ADD_A(add_a), .TX_END(tx_end), .ERR_CLR(err_clr),
    .START(start), .LINE_SYNC(line_sync), .BUSY(busy), .DIRTY(dirty),
    .ERR_TIMEOUT(err_timeout), .UPD_CNT(upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    we_a = 1'b0;
    force_upd = 1'b0;
    err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("first_sync", line_sync, 1);
  endtask

  task automatic wait_sync(input int max);
    int n = 0;
    while (!line_sync && n < max) begin
      step();
      n++;
    end
    check("sync_wait", line_sync, 1);
  endtask

  task automatic measure(output int p);
    p = 0;
    do begin
      step();
      p++;
    end while (!line_sync && p < 300);
  endtask

  task automatic write_reg(input logic [2:0] a);
    we_a = 1'b1;
    add_a = a;
    step();
    we_a = 1'b0;
  endtask

  initial begin
    int n, p, bad;
    vecs[0] = '{1'b1, 1'b0, 3'b000, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 3'b100, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 1'b1, 3'b111, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 3'b011, 1'b0, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 3'b000, 1'b0, 2'b10};
    vecs[5] = '{1'b0, 1'b1, 3'b001, 1'b0, 2'b11};
    vecs[6] = '{1'b1, 1'b0, 3'b000, 1'b1, 2'b11};
    vecs[7] = '{1'b1, 1'b1, 3'b110, 1'b0, 2'b00};
    vecs[8] = '{1'b0, 1'b1, 3'b000, 1'b0, 2'b01};
    #2;
    check("rst_start", start, 0);
    check("rst_sync", line_sync, 0);
    check("rst_busy", busy, 0);
    check("rst_dirty", dirty, 0);
    check("rst_err", err_timeout, 0);
    check("rst_upd", upd_cnt, 0);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      we_a = vecs[i].we;
      add_a = vecs[i].add;
      force_upd = vecs[i].frc;
      step();
      we_a = 1'b0;
      force_upd = 1'b0;
      check($sformatf("vec%0d_dirty", i), dirty, vecs[i].exp_dirty);
      check($sformatf("vec%0d_start", i), start, 0);
    end

    enable = 1'b1;
    line_period = 16'd100;
    do_reset();
    write_reg(3'b010);
    check("a_dirty", dirty, 2'b10);
    wait_sync(200);
    check("a_start_at_sync", start, 0);
    step();
    check("a_start", start, 1);
    check("a_dirty_clr", dirty, 0);
    check("a_busy", busy, 1);
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    check("a_start_fall", start, 0);
    check("a_upd", upd_cnt, 1);
    check("a_holdoff_busy", busy, 1);
    wait_sync(200);
    step();
    check("a_idle_busy", busy, 0);

    do_reset();
    write_reg(3'b010);
    wait_sync(200);
    we_a = 1'b1;
    add_a = 3'b000;
    step();
    we_a = 1'b0;
    check("b_start", start, 1);
    check("b_dirty_win", dirty, 2'b01);
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    check("b_upd1", upd_cnt, 1);
    wait_sync(200);
    check("b_hold_start", start, 0);
    step();
    check("b_exit_busy", busy, 0);
    wait_sync(200);
    step();
    check("b_start2", start, 1);
    check("b_dirty2", dirty, 0);
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    check("b_upd2", upd_cnt, 2);

    do_reset();
    write_reg(3'b010);
    wait_sync(200);
    step();
    check("c_start", start, 1);
    n = 1;
    while (start && n < 200) begin
      step();
      if (start) n++;
    end
    check("c_timeout_len", n, 64);
    check("c_err", err_timeout, 1);
    check("c_dirty_restore", dirty, 2'b10);
    check("c_busy", busy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("c_err_clr", err_timeout, 0);
    wait_sync(200);
    step();
    check("c_start2", start, 1);
    repeat (63) step();
    check("c_start_last", start, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("c_err_wins", err_timeout, 1);
    check("c_start_fall2", start, 0);

    tx_end = 1'b1;
    do_reset();
    write_reg(3'b010);
    wait_sync(200);
    step();
    check("d_start", start, 1);
    enable = 1'b0;
    repeat (10) step();
    check("d_stuck_start", start, 1);
    check("d_stuck_upd", upd_cnt, 0);
    tx_end = 1'b0;
    step();
    check("d_low_start", start, 1);
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    check("d_done_start", start, 0);
    check("d_done_upd", upd_cnt, 1);
    enable = 1'b1;

    do_reset();
    write_reg(3'b011);
    wait_sync(200);
    step();
    check("e_start", start, 1);
    rst_n = 1'b0;
    #1;
    check("e_async_start", start, 0);
    check("e_async_busy", busy, 0);
    check("e_async_dirty", dirty, 0);
    check("e_async_sync", line_sync, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (250) begin
      step();
      if (start) bad++;
    end
    check("e_no_relaunch", bad, 0);
    check("e_upd", upd_cnt, 0);

    do_reset();
    write_reg(3'b010);
    enable = 1'b0;
    step();
    wait_sync(200);
    step();
    check("f_no_start", start, 0);
    check("f_dirty_kept", dirty, 2'b10);
    enable = 1'b1;

    line_period = 16'd0;
    do_reset();
    measure(p);
    check("g_period_lp0", p, 2);
    line_period = 16'd1;
    measure(p);
    measure(p);
    check("g_period_lp1", p, 2);
    line_period = 16'd100;
    do_reset();
    measure(p);
    check("g_period_lp100", p, 100);
    repeat (49) step();
    line_period = 16'd10;
    step();
    check("g_wrap_nosync", line_sync, 0);
    step();
    check("g_wrap_sync", line_sync, 1);
    measure(p);
    check("g_period_lp10", p, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
